msdap_conv_alu: RTL and testbench
=================================

# msdap_conv_alu

Convolution engine for the MSDAP channel, directly downstream of the control FSM. It is cleared by `alu_clear`, runs while `alu_en` is high, and walks the Rj, coefficient and data memories. It computes y(n) = (…((u1)/2 + u2)/2 + … + u16)/2, where each u_j is the signed sum of x(n−k) over the r_j coefficients of group j. When finished it raises `conv_done` and holds the 40-bit result for the P2S load.

## Interface
- DATA_W, 16: sample and memory word width
- ACC_W, 40: accumulator and result width
- N_RJ, 16: number of Rj groups
- N_COEFF, 512: coefficient memory depth
- DATA_DEPTH, 256: data memory depth (circular sample history)

- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low; clock clk
- alu_clear  in  1  one-cycle pulse (controller WRITE_DATA): abort, clear, arm
- alu_en  in  1  run enable (controller READ_CONV); low = stall
- newest_addr  in  8  data-memory address of the sample being written; sampled on alu_clear
- rj_rdata  in  16  Rj memory read data; [8:0] = group length
- coeff_rdata  in  16  coefficient word; [8] sign (1 = subtract), [7:0] delay k
- data_rdata  in  16  signed sample x
- rj_addr  out  4  Rj memory read address
- coeff_addr  out  9  coefficient memory read address
- data_addr  out  8  data memory read address
- y  out  40  convolution result, registered
- conv_done  out  1  result valid; held until next alu_clear

## Operation
- Memories are synchronous-read. An address driven in state S gives data in state S+1. Addresses are combinational from registers and state.
- Registers:
  - acc[39:0]
  - j[3:0]
  - cptr[8:0]: coefficient pointer, wraps mod 512
  - cnt[8:0]
  - sign
  - base[7:0] (latched newest_addr)
- FSM states:
  - IDLE: drive rj_addr=0, coeff_addr=cptr, data_addr=0. Stay until alu_clear.
  - RJ_FETCH: rj_addr=j → RJ_LATCH.
  - RJ_LATCH: cnt←rj_rdata[8:0]. If cnt==0 → SHIFT, else → COEFF_FETCH.
  - COEFF_FETCH: coeff_addr=cptr → DATA_FETCH.
  - DATA_FETCH: data_addr=(base − coeff_rdata[7:0]) mod 256. sign←coeff_rdata[8]. → ACCUM.
  - ACCUM: acc ← acc ± (sext40(data_rdata) << 16). cptr++, cnt−−. If the old cnt==1 → SHIFT, else → COEFF_FETCH.
  - SHIFT: acc ← acc >>> 1 (arithmetic). If j==15 → DONE, else j++ and → RJ_FETCH.
  - DONE: y←acc, conv_done←1. Stay until alu_clear.
- alu_clear in any state (highest priority):
  - acc, j, cptr, cnt ← 0; base←newest_addr; conv_done←0; state → RJ_FETCH.
  - y keeps its old value.
- alu_en low in any busy state (RJ_FETCH..SHIFT): all registers and state hold; addresses are re-driven unchanged. IDLE and DONE ignore alu_en.
- Arithmetic:
  - Two's complement, 40-bit wrap, no saturation.
  - Samples that precede the stream read as 0, because the controller zero-fills data memory on clear; the address wraps mod 256.
- If Σrj exceeds 512, cptr wraps to 0 and the computation continues. No error is flagged.

## Timing
- Reset values:
  - Outputs: y=0, conv_done=0, rj_addr=0, coeff_addr=0, data_addr=0.
  - Internal: state IDLE, all registers 0.
- Latency from the alu_clear cycle to conv_done high = 1 + 3·16 + 3·Σrj cycles, assuming alu_en is continuously high from the cycle after clear.
  - Worst case (Σrj=512): 1585 cycles.
  - The system clock must give ≥1600 cycles per frame.
- conv_done and y change on the same edge (entry to DONE).
- Simultaneous alu_clear and alu_en: clear wins.
- reset_n low mid-run: return to reset values on the next edge, including y.

## Structure
- Shared msdap_pkg holds:
  - the conv state enum
  - constants for DATA_W, ACC_W, N_RJ, N_COEFF, DATA_DEPTH
  - coefficient field positions (SIGN_BIT=8, K_MSB=7)
  - FRAC_SHIFT=16
- One natural sub-module, msdap_conv_mac: sign select, add/sub and arithmetic shift on acc, with clear/accum/shift strobes. The FSM and address generation stay in msdap_conv_alu.

## Test plan
- Reset: hold reset_n low 2 cycles → y=0, conv_done=0, all addresses 0, conv_done stays 0 with alu_en high and no clear.
- Rj[0]=1, others 0; coeff[0]=0x000; newest_addr=0; x[0]=0x0001; clear then alu_en → y=0x00_0000_0001, conv_done exactly 52 cycles after the clear cycle.
- Same stimulus with coeff[0]=0x100 → y=0xFF_FFFF_FFFF (−1).
- Wrap check: newest_addr=3, coeff[0]=0x005 → data_addr=0xFE in DATA_FETCH.
- Large-group check: Rj[15]=32, others 0; all coeff=0x000; x[newest]=0x7FFF → y=0x07_FFF0_0000, conv_done at 145 cycles.
- Control check:
  - Drop alu_en for 10 cycles mid-group → addresses held, final y unchanged, done 10 cycles later.
  - Pulse alu_clear mid-run → conv_done=0, y unchanged, restart from j=0 with cptr=0.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared constants, field positions and the conv FSM state type for the MSDAP datapath.
package msdap_pkg;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 40;
    localparam int N_RJ       = 16;
    localparam int N_COEFF    = 512;
    localparam int DATA_DEPTH = 256;

    localparam int RJ_AW      = $clog2(N_RJ);
    localparam int COEFF_AW   = $clog2(N_COEFF);
    localparam int DATA_AW    = $clog2(DATA_DEPTH);
    localparam int CNT_W      = 9;

    // Coefficient word layout: [8] sign (1 = subtract), [7:0] delay k.
    localparam int SIGN_BIT   = 8;
    localparam int K_MSB      = 7;

    // Samples enter the accumulator with 16 fractional bits.
    localparam int FRAC_SHIFT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RJ_FETCH,
        S_RJ_LATCH,
        S_COEFF_FETCH,
        S_DATA_FETCH,
        S_ACCUM,
        S_SHIFT,
        S_DONE
    } conv_state_e;

    // Sign-extend a sample to the accumulator width and align it above the fraction.
    function automatic logic [ACC_W-1:0] sample_to_acc(input logic [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W-FRAC_SHIFT){x[DATA_W-1]}}, x, {FRAC_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/msdap_conv_mac.sv
// Accumulator for the convolution: clear, signed add/subtract of a sample, and
// the arithmetic halving applied after each Rj group.
module msdap_conv_mac
    import msdap_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_accum,
    input  logic              i_shift,
    input  logic              i_sub,
    input  logic [DATA_W-1:0] i_data,
    output logic [ACC_W-1:0]  o_acc,
    output logic [ACC_W-1:0]  o_acc_shr
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_term;

    assign w_term    = sample_to_acc(i_data);
    // Halved value is exported so the top can capture the final result on the
    // same edge that performs the last shift.
    assign o_acc_shr = {r_acc[ACC_W-1], r_acc[ACC_W-1:1]};
    assign o_acc     = r_acc;

    // Accumulator update; clear beats accumulate beats shift.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_accum)
            r_acc <= i_sub ? (r_acc - w_term) : (r_acc + w_term);
        else if (i_shift)
            r_acc <= o_acc_shr;
    end

endmodule

// File: rtl/msdap_conv_alu.sv
// MSDAP convolution engine: walks Rj, coefficient and data memories and produces
// y(n) = (...((u1)/2 + u2)/2 + ... + u16)/2 in 40-bit two's complement.
module msdap_conv_alu
    import msdap_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_alu_clear,
    input  logic                i_alu_en,
    input  logic [DATA_AW-1:0]  i_newest_addr,
    input  logic [DATA_W-1:0]   i_rj_rdata,
    input  logic [DATA_W-1:0]   i_coeff_rdata,
    input  logic [DATA_W-1:0]   i_data_rdata,
    output logic [RJ_AW-1:0]    o_rj_addr,
    output logic [COEFF_AW-1:0] o_coeff_addr,
    output logic [DATA_AW-1:0]  o_data_addr,
    output logic [ACC_W-1:0]    o_y,
    output logic                o_conv_done
);

    conv_state_e         r_state;
    logic [RJ_AW-1:0]    r_j;
    logic [COEFF_AW-1:0] r_cptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sign;
    logic [DATA_AW-1:0]  r_base;
    logic [DATA_AW-1:0]  r_daddr;
    logic [ACC_W-1:0]    r_y;
    logic                r_conv_done;

    logic [DATA_AW-1:0]  w_daddr_calc;
    logic [CNT_W-1:0]    w_rj_len;
    logic                w_accum;
    logic                w_shift;
    logic [ACC_W-1:0]    w_acc;
    logic [ACC_W-1:0]    w_acc_shr;
    logic                w_unused_bits;

    assign w_rj_len      = i_rj_rdata[CNT_W-1:0];
    // Delay taps reach back from the newest sample; mod-256 wrap is intentional.
    assign w_daddr_calc  = r_base - i_coeff_rdata[K_MSB:0];
    assign w_accum       = (r_state == S_ACCUM) && i_alu_en && !i_alu_clear;
    assign w_shift       = (r_state == S_SHIFT) && i_alu_en && !i_alu_clear;
    assign w_unused_bits = ^{i_rj_rdata[DATA_W-1:CNT_W], i_coeff_rdata[DATA_W-1:SIGN_BIT+1], w_acc};

    msdap_conv_mac u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (i_alu_clear),
        .i_accum   (w_accum),
        .i_shift   (w_shift),
        .i_sub     (r_sign),
        .i_data    (i_data_rdata),
        .o_acc     (w_acc),
        .o_acc_shr (w_acc_shr)
    );

    // Memory addresses; data address is held after DATA_FETCH so a stalled
    // ACCUM keeps reading the same sample.
    always_comb begin
        o_rj_addr    = r_j;
        o_coeff_addr = r_cptr;
        o_data_addr  = r_daddr;
        if (r_state == S_IDLE) begin
            o_rj_addr   = '0;
            o_data_addr = '0;
        end else if (r_state == S_DATA_FETCH) begin
            o_data_addr = w_daddr_calc;
        end
    end

    // Control FSM and result register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_cptr      <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_base      <= '0;
            r_daddr     <= '0;
            r_y         <= '0;
            r_conv_done <= 1'b0;
        end else if (i_alu_clear) begin
            r_state     <= S_RJ_FETCH;
            r_j         <= '0;
            r_cptr      <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_base      <= i_newest_addr;
            r_daddr     <= '0;
            r_conv_done <= 1'b0;
        end else begin
            case (r_state)
                S_RJ_FETCH: begin
                    if (i_alu_en)
                        r_state <= S_RJ_LATCH;
                end
                S_RJ_LATCH: begin
                    if (i_alu_en) begin
                        r_cnt   <= w_rj_len;
                        r_state <= (w_rj_len == '0) ? S_SHIFT : S_COEFF_FETCH;
                    end
                end
                S_COEFF_FETCH: begin
                    if (i_alu_en)
                        r_state <= S_DATA_FETCH;
                end
                S_DATA_FETCH: begin
                    if (i_alu_en) begin
                        r_sign  <= i_coeff_rdata[SIGN_BIT];
                        r_daddr <= w_daddr_calc;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_alu_en) begin
                        r_cptr  <= r_cptr + COEFF_AW'(1);
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_state <= (r_cnt == CNT_W'(1)) ? S_SHIFT : S_COEFF_FETCH;
                    end
                end
                S_SHIFT: begin
                    if (i_alu_en) begin
                        if (r_j == RJ_AW'(N_RJ-1)) begin
                            r_y         <= w_acc_shr;
                            r_conv_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_j     <= r_j + RJ_AW'(1);
                            r_state <= S_RJ_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_y         = r_y;
    assign o_conv_done = r_conv_done;

endmodule

// File: tb/tb_msdap_conv_alu.sv
// Directed bench for msdap_conv_alu with synchronous-read memory models.
module tb_msdap_conv_alu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_clear, alu_en;
    logic [7:0]  newest_addr;
    logic [15:0] rj_rdata, coeff_rdata, data_rdata;
    logic [3:0]  rj_addr;
    logic [8:0]  coeff_addr;
    logic [7:0]  data_addr;
    logic [39:0] y;
    logic        conv_done;

    logic [15:0] rj_mem [16];
    logic [15:0] coeff_mem [512];
    logic [15:0] data_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    msdap_conv_alu dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_alu_clear   (alu_clear),
        .i_alu_en      (alu_en),
        .i_newest_addr (newest_addr),
        .i_rj_rdata    (rj_rdata),
        .i_coeff_rdata (coeff_rdata),
        .i_data_rdata  (data_rdata),
        .o_rj_addr     (rj_addr),
        .o_coeff_addr  (coeff_addr),
        .o_data_addr   (data_addr),
        .o_y           (y),
        .o_conv_done   (conv_done)
    );

    always @(posedge clk) begin
        rj_rdata    <= rj_mem[rj_addr];
        coeff_rdata <= coeff_mem[coeff_addr];
        data_rdata  <= data_mem[data_addr];
    end

    typedef struct {
        int          idx;
        logic [15:0] len;
        logic [15:0] cw;
        logic [7:0]  newest;
        logic [7:0]  xa;
        logic [15:0] xv;
        logic [39:0] ey;
        int          elat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input int idx, input logic [15:0] len, input logic [15:0] cw,
                         input logic [7:0] newest, input logic [7:0] xa, input logic [15:0] xv);
        for (int i = 0; i < 16; i++)  rj_mem[i] = 16'h0;
        for (int i = 0; i < 512; i++) coeff_mem[i] = cw;
        for (int i = 0; i < 256; i++) data_mem[i] = 16'h0;
        rj_mem[idx]  = len;
        data_mem[xa] = xv;
        newest_addr  = newest;
    endtask

    // Pulse clear with enable high; returns in cycle 1 of the run.
    task automatic start_run();
        @(negedge clk);
        alu_clear = 1'b1;
        alu_en    = 1'b1;
        @(negedge clk);
        alu_clear = 1'b0;
    endtask

    // Continue from cycle 'cyc' until conv_done; returns cycle index it rose in.
    task automatic wait_done(input int cyc, output int lat);
        lat = cyc;
        while (!conv_done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (!conv_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: conv_done never rose within %0d cycles", lat);
        end
    endtask

    initial begin
        int lat;
        reset_n     = 1'b0;
        alu_clear   = 1'b0;
        alu_en      = 1'b0;
        newest_addr = 8'h0;
        setup(0, 16'd0, 16'h0, 8'h0, 8'h0, 16'h0);

        vecs[0] = '{0,  16'd1,  16'h000, 8'h00, 8'h00, 16'h0001, 40'h00_0000_0001, 52};
        vecs[1] = '{0,  16'd1,  16'h100, 8'h00, 8'h00, 16'h0001, 40'hFF_FFFF_FFFF, 52};
        vecs[2] = '{15, 16'd32, 16'h000, 8'h10, 8'h10, 16'h7FFF, 40'h07_FFF0_0000, 145};
        vecs[3] = '{0,  16'd1,  16'h000, 8'h00, 8'h00, 16'h8000, 40'hFF_FFFF_8000, 52};
        vecs[4] = '{0,  16'd1,  16'h100, 8'h00, 8'h00, 16'h8000, 40'h00_0000_8000, 52};
        vecs[5] = '{1,  16'd1,  16'h000, 8'h00, 8'h00, 16'h0004, 40'h00_0000_0008, 52};
        vecs[6] = '{0,  16'd1,  16'h002, 8'h05, 8'h03, 16'h0010, 40'h00_0000_0010, 52};

        // Reset
        repeat (2) @(negedge clk);
        chk("reset_y", y, 0);
        chk("reset_done", conv_done, 0);
        chk("reset_rj_addr", rj_addr, 0);
        chk("reset_coeff_addr", coeff_addr, 0);
        chk("reset_data_addr", data_addr, 0);
        reset_n = 1'b1;
        alu_en  = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_done", conv_done, 0);

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            setup(vecs[v].idx, vecs[v].len, vecs[v].cw, vecs[v].newest, vecs[v].xa, vecs[v].xv);
            start_run();
            wait_done(1, lat);
            chk($sformatf("vec%0d_y", v), y, vecs[v].ey);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].elat);
        end

        // Address wrap: 3 - 5 = 0xFE in DATA_FETCH (cycle 4)
        setup(0, 16'd1, 16'h005, 8'h03, 8'hFE, 16'h0002);
        start_run();
        repeat (3) @(negedge clk);
        chk("wrap_data_addr", data_addr, 8'hFE);
        wait_done(4, lat);
        chk("wrap_y", y, 40'h2);
        chk("wrap_latency", lat, 52);

        // Stall for 10 cycles in DATA_FETCH of the second coefficient (cycle 7)
        setup(0, 16'd2, 16'h000, 8'h00, 8'h00, 16'h0001);
        coeff_mem[1]  = 16'h001;
        data_mem[255] = 16'h0003;
        start_run();
        repeat (6) @(negedge clk);
        chk("stall_pre_data_addr", data_addr, 8'hFF);
        alu_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_data_addr", data_addr, 8'hFF);
        chk("stall_coeff_addr", coeff_addr, 9'd1);
        chk("stall_no_done", conv_done, 0);
        alu_en = 1'b1;
        wait_done(17, lat);
        chk("stall_y", y, 40'h4);
        chk("stall_latency", lat, 65);

        // Mid-run clear: restart while deep into group 15
        setup(15, 16'd32, 16'h000, 8'h10, 8'h10, 16'h7FFF);
        start_run();
        repeat (59) @(negedge clk);
        chk("midrun_done_low", conv_done, 0);
        chk("midrun_y_held", y, 40'h4);
        start_run();
        chk("restart_done_low", conv_done, 0);
        chk("restart_y_held", y, 40'h4);
        chk("restart_rj_addr", rj_addr, 0);
        chk("restart_coeff_addr", coeff_addr, 0);
        wait_done(1, lat);
        chk("restart_y", y, 40'h07_FFF0_0000);
        chk("restart_latency", lat, 145);

        // Clear after DONE drops conv_done and keeps y
        @(negedge clk);
        alu_clear = 1'b1;
        alu_en    = 1'b0;
        @(negedge clk);
        alu_clear = 1'b0;
        chk("post_clear_done", conv_done, 0);
        chk("post_clear_y", y, 40'h07_FFF0_0000);

        // Reset mid-run returns y to 0
        alu_en = 1'b1;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_y", y, 0);
        chk("midreset_done", conv_done, 0);
        chk("midreset_coeff_addr", coeff_addr, 0);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
